// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller for an asynchronous FIFO: owns the binary and
// Gray write pointers, synchronises the read Gray pointer, and derives full/level/overflow.
module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic                wovf_clr,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wclken,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  typedef logic [ADDRSIZE:0] ptr_t;

  ptr_t wbin_q, wbin_d;
  ptr_t wgray_q, wgray_d;
  ptr_t wlevel_q, wlevel_d;
  ptr_t sync_q [SYNC_STAGES];
  ptr_t sync_d [SYNC_STAGES];
  logic wfull_q, wfull_d;
  logic walmost_full_q, walmost_full_d;
  logic woverflow_q, woverflow_d;

  ptr_t wq_rptr;
  ptr_t rbin_sync;
  ptr_t full_pattern;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain shift register: no logic between stages so each stage only ever sees
  // a single-bit Gray transition from the read domain.
  always_comb begin
    sync_d[0] = rptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wq_rptr      = sync_q[SYNC_STAGES-1];
  assign rbin_sync    = gray2bin(wq_rptr);
  // Full when the write pointer has lapped the read pointer exactly once.
  assign full_pattern = {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    wclken         = winc & ~wfull_q;
    wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, wclken};
    wgray_d        = wbin_d ^ (wbin_d >> 1);
    wfull_d        = (wgray_d == full_pattern);
    wlevel_d       = wbin_d - rbin_sync;
    walmost_full_d = (wlevel_d >= PW'(AFULL_THRESH));
    woverflow_d    = woverflow_q;
    if (winc && wfull_q) begin
      woverflow_d = 1'b1;
    end else if (wovf_clr) begin
      woverflow_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule
